// File: rtl/alu_pkg.sv
// Shared ALU definitions: op code encoding, widths and an op-legality helper.
// Imported by the ALU itself and by every block that drives or decodes ALU ops.
package alu_pkg;

  localparam int ALU_OP_W = 4;

  typedef logic [ALU_OP_W-1:0] alu_op_t;

  localparam alu_op_t ALU_ADD   = 4'h0;
  localparam alu_op_t ALU_SUB   = 4'h1;
  localparam alu_op_t ALU_SLL   = 4'h2;
  localparam alu_op_t ALU_SLT   = 4'h3;
  localparam alu_op_t ALU_SLTU  = 4'h4;
  localparam alu_op_t ALU_XOR   = 4'h5;
  localparam alu_op_t ALU_SRL   = 4'h6;
  localparam alu_op_t ALU_SRA   = 4'h7;
  localparam alu_op_t ALU_OR    = 4'h8;
  localparam alu_op_t ALU_AND   = 4'h9;
  localparam alu_op_t ALU_LUI   = 4'hA;
  localparam alu_op_t ALU_AUIPC = 4'hB;

  localparam alu_op_t ALU_OP_MAX = 4'hB;

  // Which requester wins when both are eligible in the same cycle.
  typedef enum logic {
    RR_REQ0 = 1'b0,
    RR_REQ1 = 1'b1
  } rr_sel_e;

  // Op codes above the last defined op are reported back as errors.
  function automatic logic op_is_illegal(input alu_op_t op);
    return (op > ALU_OP_MAX);
  endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// One requester's request/response channel to the shared-ALU arbiter.
// master = requester side, slave = arbiter side.
interface alu_share_arbiter_if
  import alu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
);

  // Request channel
  logic             req_valid;
  logic             req_ready;
  logic [XLEN-1:0]  req_a;
  logic [XLEN-1:0]  req_b;
  alu_op_t          req_op;
  logic [TAG_W-1:0] req_tag;

  // Response channel
  logic             rsp_valid;
  logic             rsp_ready;
  logic [XLEN-1:0]  rsp_result;
  logic             rsp_zero;
  logic             rsp_err;
  logic [TAG_W-1:0] rsp_tag;

  modport master (
    output req_valid, req_a, req_b, req_op, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err, rsp_tag
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err, rsp_tag
  );

endinterface

// File: rtl/alu_rsp_slot.sv
// One-deep response register for a single requester. Holds result/zero/err/tag
// stable until the consumer takes it, and can be drained and refilled in the
// same cycle (slot_free already accounts for a same-cycle handshake).
module alu_rsp_slot #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [XLEN-1:0]  load_result,
  input  logic             load_zero,
  input  logic             load_err,
  input  logic [TAG_W-1:0] load_tag,
  input  logic             rsp_ready,
  output logic             slot_free,
  output logic             rsp_valid,
  output logic [XLEN-1:0]  rsp_result,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic [TAG_W-1:0] rsp_tag
);

  logic             valid_r;
  logic [XLEN-1:0]  result_r;
  logic             zero_r;
  logic             err_r;
  logic [TAG_W-1:0] tag_r;

  // Capture a new result on load, otherwise drop valid once the consumer takes it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_r  <= 1'b0;
      result_r <= {XLEN{1'b0}};
      zero_r   <= 1'b0;
      err_r    <= 1'b0;
      tag_r    <= {TAG_W{1'b0}};
    end else if (load) begin
      valid_r  <= 1'b1;
      result_r <= load_result;
      zero_r   <= load_zero;
      err_r    <= load_err;
      tag_r    <= load_tag;
    end else if (rsp_ready) begin
      valid_r  <= 1'b0;
    end else begin
      valid_r  <= valid_r;
    end
  end

  assign slot_free  = !valid_r | rsp_ready;
  assign rsp_valid  = valid_r;
  assign rsp_result = result_r;
  assign rsp_zero   = zero_r;
  assign rsp_err    = err_r;
  assign rsp_tag    = tag_r;

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external combinational ALU between two requesters. At most one
// request is granted per cycle (round-robin on contention); the ALU output of
// the granted op is captured into that requester's response slot, so results
// appear one cycle after the grant. A stalled slot only blocks its own requester.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_share_arbiter_if.slave   req0,
  alu_share_arbiter_if.slave   req1,
  output logic [XLEN-1:0]      alu_operand_a,
  output logic [XLEN-1:0]      alu_operand_b,
  output alu_op_t              alu_op,
  input  logic [XLEN-1:0]      alu_result,
  input  logic                 alu_zero
);

  logic    free0_s;
  logic    free1_s;
  logic    elig0_s;
  logic    elig1_s;
  logic    grant0_s;
  logic    grant1_s;
  logic    op_err_s;
  rr_sel_e rr_ptr_r;

  // A requester is eligible only when its response slot can take the result;
  // nothing is granted while reset is asserted.
  assign elig0_s = rst_n & req0.req_valid & free0_s;
  assign elig1_s = rst_n & req1.req_valid & free1_s;

  // Sole eligible requester wins; on contention rr_ptr decides.
  assign grant0_s = elig0_s & (!elig1_s | (rr_ptr_r == RR_REQ0));
  assign grant1_s = elig1_s & (!elig0_s | (rr_ptr_r == RR_REQ1));

  assign req0.req_ready = grant0_s;
  assign req1.req_ready = grant1_s;

  // After any grant the other requester gets priority next time both compete.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_r <= RR_REQ0;
    end else if (grant0_s) begin
      rr_ptr_r <= RR_REQ1;
    end else if (grant1_s) begin
      rr_ptr_r <= RR_REQ0;
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

  // Steer the granted request onto the ALU; park it on ADD 0,0 when idle.
  always_comb begin
    alu_operand_a = {XLEN{1'b0}};
    alu_operand_b = {XLEN{1'b0}};
    alu_op        = ALU_ADD;
    if (grant0_s) begin
      alu_operand_a = req0.req_a;
      alu_operand_b = req0.req_b;
      alu_op        = req0.req_op;
    end else if (grant1_s) begin
      alu_operand_a = req1.req_a;
      alu_operand_b = req1.req_b;
      alu_op        = req1.req_op;
    end else begin
      alu_operand_a = {XLEN{1'b0}};
      alu_operand_b = {XLEN{1'b0}};
      alu_op        = ALU_ADD;
    end
  end

  // Only the granted op reaches the ALU, so its legality applies to whichever slot loads.
  assign op_err_s = op_is_illegal(alu_op);

  alu_rsp_slot #(
    .XLEN  (XLEN),
    .TAG_W (TAG_W)
  ) u_slot0 (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (grant0_s),
    .load_result (alu_result),
    .load_zero   (alu_zero),
    .load_err    (op_err_s),
    .load_tag    (req0.req_tag),
    .rsp_ready   (req0.rsp_ready),
    .slot_free   (free0_s),
    .rsp_valid   (req0.rsp_valid),
    .rsp_result  (req0.rsp_result),
    .rsp_zero    (req0.rsp_zero),
    .rsp_err     (req0.rsp_err),
    .rsp_tag     (req0.rsp_tag)
  );

  alu_rsp_slot #(
    .XLEN  (XLEN),
    .TAG_W (TAG_W)
  ) u_slot1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (grant1_s),
    .load_result (alu_result),
    .load_zero   (alu_zero),
    .load_err    (op_err_s),
    .load_tag    (req1.req_tag),
    .rsp_ready   (req1.rsp_ready),
    .slot_free   (free1_s),
    .rsp_valid   (req1.rsp_valid),
    .rsp_result  (req1.rsp_result),
    .rsp_zero    (req1.rsp_zero),
    .rsp_err     (req1.rsp_err),
    .rsp_tag     (req1.rsp_tag)
  );

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed scenarios followed by random traffic,
// all checked against a transaction-level model of the arbitration rules.
module tb_alu_share_arbiter;
  import alu_pkg::*;

  localparam int XLEN  = 32;
  localparam int TAG_W = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  alu_share_arbiter_if #(.XLEN(XLEN), .TAG_W(TAG_W)) if0 ();
  alu_share_arbiter_if #(.XLEN(XLEN), .TAG_W(TAG_W)) if1 ();

  logic [XLEN-1:0] alu_operand_a;
  logic [XLEN-1:0] alu_operand_b;
  alu_op_t         alu_op;
  logic [XLEN-1:0] alu_result;
  logic            alu_zero;

  alu_share_arbiter #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req0          (if0),
    .req1          (if1),
    .alu_operand_a (alu_operand_a),
    .alu_operand_b (alu_operand_b),
    .alu_op        (alu_op),
    .alu_result    (alu_result),
    .alu_zero      (alu_zero)
  );

  // Behavioural RV32I ALU; unsupported ops return 0.
  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'h0:    return a + b;
      4'h1:    return a - b;
      4'h2:    return a << b[4:0];
      4'h3:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'h4:    return (a < b) ? 32'd1 : 32'd0;
      4'h5:    return a ^ b;
      4'h6:    return a >> b[4:0];
      4'h7:    return $unsigned($signed(a) >>> b[4:0]);
      4'h8:    return a | b;
      4'h9:    return a & b;
      4'hA:    return b;
      4'hB:    return a + b;
      default: return 32'd0;
    endcase
  endfunction

  assign alu_result = ref_alu(alu_op, alu_operand_a, alu_operand_b);
  assign alu_zero   = (alu_result == 32'd0);

  // Stimulus state per requester
  logic             r_valid [2];
  logic [XLEN-1:0]  r_a     [2];
  logic [XLEN-1:0]  r_b     [2];
  logic [3:0]       r_op    [2];
  logic [TAG_W-1:0] r_tag   [2];
  logic             s_ready [2];

  // Model: expected content of each response slot and who wins a tie next
  logic             e_valid  [2];
  logic [XLEN-1:0]  e_result [2];
  logic             e_zero   [2];
  logic             e_err    [2];
  logic [TAG_W-1:0] e_tag    [2];
  int               prio;
  int               last_g;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    if0.req_valid = r_valid[0]; if0.req_a = r_a[0]; if0.req_b = r_b[0];
    if0.req_op = r_op[0]; if0.req_tag = r_tag[0]; if0.rsp_ready = s_ready[0];
    if1.req_valid = r_valid[1]; if1.req_a = r_a[1]; if1.req_b = r_b[1];
    if1.req_op = r_op[1]; if1.req_tag = r_tag[1]; if1.rsp_ready = s_ready[1];
  endtask

  task automatic new_payload(input int n);
    r_a[n]   = $urandom;
    r_b[n]   = $urandom;
    r_op[n]  = 4'($urandom_range(0, 15));
    r_tag[n] = TAG_W'($urandom_range(0, 15));
  endtask

  task automatic chk_rsp(input int n);
    logic v, z, e;
    logic [XLEN-1:0] r;
    logic [TAG_W-1:0] t;
    if (n == 0) begin
      v = if0.rsp_valid; r = if0.rsp_result; z = if0.rsp_zero; e = if0.rsp_err; t = if0.rsp_tag;
    end else begin
      v = if1.rsp_valid; r = if1.rsp_result; z = if1.rsp_zero; e = if1.rsp_err; t = if1.rsp_tag;
    end
    chk($sformatf("rsp%0d_valid", n), v, e_valid[n]);
    if (e_valid[n] || !rst_n) begin
      chk($sformatf("rsp%0d_result", n), r, e_result[n]);
      chk($sformatf("rsp%0d_zero", n), z, e_zero[n]);
      chk($sformatf("rsp%0d_err", n), e, e_err[n]);
      chk($sformatf("rsp%0d_tag", n), t, e_tag[n]);
    end
  endtask

  // One clock cycle: apply inputs, check grant/ALU drive mid-cycle, advance
  // the model across the edge, then check both response slots.
  // exp_g: -2 = no directed expectation, -1 = nobody, 0/1 = that requester.
  task automatic step(input int exp_g);
    int   g;
    logic free_m [2];
    logic elig_m [2];
    drive();
    g = -1;
    if (rst_n) begin
      for (int n = 0; n < 2; n++) begin
        free_m[n] = !e_valid[n] || s_ready[n];
        elig_m[n] = r_valid[n] && free_m[n];
      end
      if (elig_m[0] && elig_m[1]) g = prio;
      else if (elig_m[0])         g = 0;
      else if (elig_m[1])         g = 1;
    end
    @(negedge clk);
    chk("req0_ready", if0.req_ready, g == 0);
    chk("req1_ready", if1.req_ready, g == 1);
    if (exp_g != -2) begin
      chk("req0_ready_directed", if0.req_ready, exp_g == 0);
      chk("req1_ready_directed", if1.req_ready, exp_g == 1);
    end
    if (g >= 0) begin
      chk("alu_a", alu_operand_a, r_a[g]);
      chk("alu_b", alu_operand_b, r_b[g]);
      chk("alu_op", alu_op, r_op[g]);
    end else begin
      chk("alu_a_idle", alu_operand_a, 0);
      chk("alu_b_idle", alu_operand_b, 0);
      chk("alu_op_idle", alu_op, 0);
    end
    @(posedge clk);
    #1;
    if (!rst_n) begin
      for (int n = 0; n < 2; n++) begin
        e_valid[n] = 1'b0; e_result[n] = '0; e_zero[n] = 1'b0; e_err[n] = 1'b0; e_tag[n] = '0;
      end
      prio = 0;
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (g == n) begin
          e_valid[n]  = 1'b1;
          e_result[n] = ref_alu(r_op[n], r_a[n], r_b[n]);
          e_zero[n]   = (e_result[n] == 32'd0);
          e_err[n]    = (r_op[n] > 4'd11);
          e_tag[n]    = r_tag[n];
        end else if (s_ready[n]) begin
          e_valid[n] = 1'b0;
        end
      end
      if (g >= 0) prio = 1 - g;
    end
    last_g = g;
    chk_rsp(0);
    chk_rsp(1);
  endtask

  initial begin
    for (int n = 0; n < 2; n++) begin
      r_valid[n] = 1'b1; new_payload(n); s_ready[n] = 1'b1;
      e_valid[n] = 1'b0; e_result[n] = '0; e_zero[n] = 1'b0; e_err[n] = 1'b0; e_tag[n] = '0;
    end
    prio   = 0;
    last_g = -1;
    drive();

    // Reset held with both requesting: nothing granted, responses cleared
    rst_n = 1'b0;
    repeat (3) step(-1);
    rst_n = 1'b1;
    step(0);
    r_valid[0] = 1'b0;
    step(1);
    r_valid[1] = 1'b0;
    step(-1);

    // Single op on req0
    r_valid[0] = 1'b1; r_a[0] = 32'd5; r_b[0] = 32'd7; r_op[0] = ALU_ADD; r_tag[0] = 4'd3;
    step(0);
    chk("single_result", if0.rsp_result, 32'd12);
    chk("single_zero", if0.rsp_zero, 1'b0);
    chk("single_tag", if0.rsp_tag, 4'd3);
    r_valid[0] = 1'b0;
    r_valid[1] = 1'b1; r_a[1] = 32'd1; r_b[1] = 32'd2; r_op[1] = ALU_ADD; r_tag[1] = 4'd9;
    step(1);
    r_valid[1] = 1'b0;

    // Contention: strict alternation, SUB 7-7 on req1
    r_valid[0] = 1'b1; new_payload(0);
    r_valid[1] = 1'b1; r_a[1] = 32'd7; r_b[1] = 32'd7; r_op[1] = ALU_SUB; r_tag[1] = 4'd5;
    for (int i = 0; i < 6; i++) begin
      step(i % 2);
      if (i == 1) begin
        chk("sub_result", if1.rsp_result, 32'd0);
        chk("sub_zero", if1.rsp_zero, 1'b1);
        chk("sub_tag", if1.rsp_tag, 4'd5);
      end
      new_payload(i % 2);
    end
    r_valid[0] = 1'b0; r_valid[1] = 1'b0;
    step(-1);

    // Back-pressure on rsp1: req0 keeps flowing, rsp1 held
    s_ready[1] = 1'b0;
    r_valid[1] = 1'b1; new_payload(1);
    step(1);
    new_payload(1);
    r_valid[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(0);
      new_payload(0);
    end
    s_ready[1] = 1'b1;
    step(1);
    r_valid[0] = 1'b0; r_valid[1] = 1'b0;
    repeat (2) step(-1);

    // Unsupported op code
    r_valid[0] = 1'b1; r_a[0] = 32'h1234; r_b[0] = 32'h55; r_op[0] = 4'hD; r_tag[0] = 4'hA;
    step(0);
    chk("illegal_err", if0.rsp_err, 1'b1);
    chk("illegal_result", if0.rsp_result, 32'd0);
    chk("illegal_zero", if0.rsp_zero, 1'b1);
    r_valid[0] = 1'b0;
    step(-1);

    // Reset with a response in flight: it is discarded
    s_ready[1] = 1'b0;
    r_valid[1] = 1'b1; r_a[1] = 32'h8000_0000; r_b[1] = 32'd4; r_op[1] = ALU_SRA; r_tag[1] = 4'd6;
    step(1);
    chk("sra_valid", if1.rsp_valid, 1'b1);
    chk("sra_result", if1.rsp_result, 32'hF800_0000);
    r_valid[1] = 1'b0;
    rst_n = 1'b0;
    step(-1);
    chk("rst_mid_valid", if1.rsp_valid, 1'b0);
    rst_n = 1'b1;
    s_ready[1] = 1'b1;
    repeat (3) step(-1);

    // Random traffic; a pending request keeps its payload until accepted
    for (int c = 0; c < 400; c++) begin
      for (int n = 0; n < 2; n++) begin
        if (!r_valid[n] || last_g == n) begin
          r_valid[n] = ($urandom_range(0, 3) != 0);
          new_payload(n);
        end
        s_ready[n] = ($urandom_range(0, 2) != 0);
      end
      step(-2);
    end
    r_valid[0] = 1'b0; r_valid[1] = 1'b0;
    s_ready[0] = 1'b1; s_ready[1] = 1'b1;
    repeat (2) step(-1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
